// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: OUT_SUB = A - B.
// Magnitude-ordered alignment, one-bit-per-cycle normalization, overflow/underflow flag.
module fp_subtractor_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OUT_SUB,
  output logic             Flag_SUB,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MW = MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sign_l_reg, eff_sub_reg;
  logic [EXP_W-1:0] exp_reg;
  logic [MW-1:0]    man_l_reg, man_s_reg;

  logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_small, shift;
  logic [MW-1:0]    man_a, man_b, man_big, man_small, man_small_sh;
  logic             b_gt_a, sign_big;
  logic [MW:0]      res;
  logic [EXP_W-1:0] exp_inc, exp_dec;
  logic [MW-1:0]    man_sh;
  logic             load_out;
  logic [WIDTH-1:0] out_next;
  logic             flag_next;

  // Exponent zero is treated as exact zero; denormals are not supported.
  assign exp_a = a_reg[WIDTH-2 -: EXP_W];
  assign exp_b = b_reg[WIDTH-2 -: EXP_W];
  assign man_a = (exp_a == '0) ? '0 : {1'b1, a_reg[MAN_W-1:0]};
  assign man_b = (exp_b == '0) ? '0 : {1'b1, b_reg[MAN_W-1:0]};

  assign b_gt_a       = {exp_b, man_b} > {exp_a, man_a};
  assign exp_big      = b_gt_a ? exp_b : exp_a;
  assign exp_small    = b_gt_a ? exp_a : exp_b;
  assign man_big      = b_gt_a ? man_b : man_a;
  assign man_small    = b_gt_a ? man_a : man_b;
  assign sign_big     = b_gt_a ? b_reg[WIDTH-1] : a_reg[WIDTH-1];
  assign shift        = exp_big - exp_small;
  assign man_small_sh = (32'(shift) >= MW) ? '0 : (man_small >> shift);

  assign res     = eff_sub_reg ? ({1'b0, man_l_reg} - {1'b0, man_s_reg})
                               : ({1'b0, man_l_reg} + {1'b0, man_s_reg});
  assign exp_inc = exp_reg + 1'b1;
  assign exp_dec = exp_reg - 1'b1;
  assign man_sh  = man_l_reg << 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    out_next   = OUT_SUB;
    flag_next  = Flag_SUB;
    case (state_reg)
      S_IDLE:  if (START && EN) state_next = S_ALIGN;
      S_ALIGN: state_next = S_ADDSUB;
      S_ADDSUB: begin
        if (res[MW]) begin
          load_out   = 1'b1;
          state_next = S_DONE;
          if (exp_inc == EXP_MAX) begin
            out_next  = {sign_l_reg, EXP_MAX, {MAN_W{1'b0}}};
            flag_next = 1'b1;
          end else begin
            out_next  = {sign_l_reg, exp_inc, res[MAN_W:1]};
            flag_next = 1'b0;
          end
        end else if (res[MW-1:0] == '0) begin
          load_out   = 1'b1;
          out_next   = '0;
          flag_next  = 1'b0;
          state_next = S_DONE;
        end else if (res[MW-1]) begin
          load_out   = 1'b1;
          out_next   = {sign_l_reg, exp_reg, res[MAN_W-1:0]};
          flag_next  = 1'b0;
          state_next = S_DONE;
        end else begin
          state_next = S_NORM;
        end
      end
      S_NORM: begin
        // A shift that would bring the exponent to zero cannot yield a normal result.
        if (exp_reg == EXP_W'(1)) begin
          load_out   = 1'b1;
          out_next   = '0;
          flag_next  = 1'b1;
          state_next = S_DONE;
        end else if (man_sh[MW-1]) begin
          load_out   = 1'b1;
          out_next   = {sign_l_reg, exp_dec, man_sh[MAN_W-1:0]};
          flag_next  = 1'b0;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sign_l_reg  <= 1'b0;
      eff_sub_reg <= 1'b0;
      exp_reg     <= '0;
      man_l_reg   <= '0;
      man_s_reg   <= '0;
      OUT_SUB     <= '0;
      Flag_SUB    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (START && EN) begin
          a_reg <= A;
          b_reg <= {~B[WIDTH-1], B[WIDTH-2:0]};
        end
        S_ALIGN: begin
          sign_l_reg  <= sign_big;
          eff_sub_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          exp_reg     <= exp_big;
          man_l_reg   <= man_big;
          man_s_reg   <= man_small_sh;
        end
        S_ADDSUB: man_l_reg <= res[MW-1:0];
        S_NORM: begin
          man_l_reg <= man_sh;
          exp_reg   <= exp_dec;
        end
        default: ;
      endcase
      if (load_out) begin
        OUT_SUB  <= out_next;
        Flag_SUB <= flag_next;
      end
    end
  end

  assign BUSY = (state_reg != S_IDLE);
  assign DONE = (state_reg == S_DONE);

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: directed table, handshake corners,
// and random operands against an integer-arithmetic reference model.
module tb_fp_subtractor_seq;

  logic        CLK = 1'b0;
  logic        RST, EN, START;
  logic [31:0] A, B, OUT_SUB;
  logic        Flag_SUB, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fp_subtractor_seq dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .A(A), .B(B),
    .OUT_SUB(OUT_SUB), .Flag_SUB(Flag_SUB), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        flag;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        flag;
    int          lat;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Result from plain arithmetic: integer mantissas, leading-one position, exponent bounds.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b_raw);
    res_t r;
    logic [31:0] b;
    int ea, eb, e_l, e_s, d, p, n;
    longint ma, mb, m_l, m_s, sum;
    logic s_l, s_s;
    b  = b_raw ^ 32'h8000_0000;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : longint'(a[22:0]) + (longint'(1) << 23);
    mb = (eb == 0) ? 0 : longint'(b[22:0]) + (longint'(1) << 23);
    if (eb > ea || (eb == ea && mb > ma)) begin
      e_l = eb; m_l = mb; s_l = b[31]; e_s = ea; m_s = ma; s_s = a[31];
    end else begin
      e_l = ea; m_l = ma; s_l = a[31]; e_s = eb; m_s = mb; s_s = b[31];
    end
    d   = e_l - e_s;
    m_s = (d >= 24) ? 0 : (m_s >> d);
    sum = (s_l == s_s) ? m_l + m_s : m_l - m_s;
    r.out = 32'h0; r.flag = 1'b0; r.lat = 3;
    if (sum == 0) return r;
    if (sum >= (longint'(1) << 24)) begin
      if (e_l + 1 >= 255) begin
        r.out = {s_l, 8'hFF, 23'h0}; r.flag = 1'b1;
      end else begin
        r.out = {s_l, 8'(e_l + 1), 23'(sum >> 1)};
      end
      return r;
    end
    p = 0;
    for (int k = 0; k < 24; k++) if (sum[k]) p = k;
    n = 23 - p;
    if (n < e_l) begin
      r.out = {s_l, 8'(e_l - n), 23'(sum << n)};
      r.lat = 3 + n;
    end else begin
      r.flag = 1'b1;
      r.lat  = 3 + e_l;
    end
    return r;
  endfunction

  // Called #1 after the START edge; cycle 1 is the cycle just after that edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    int c = 1;
    busy_cnt = 0;
    while (DONE !== 1'b1 && c <= 40) begin
      if (BUSY === 1'b1) busy_cnt++;
      @(posedge CLK); #1;
      c++;
    end
    if (BUSY === 1'b1) busy_cnt++;
    check("done_timeout", {31'b0, c > 40}, 32'h0);
    lat = c;
  endtask

  task automatic finish_op(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] out, output logic flag, output int lat, output int busy_cnt);
    @(posedge CLK); #1;
    START = 1'b0;
    A = $urandom;
    B = $urandom;
    wait_done(lat, busy_cnt);
    out  = OUT_SUB;
    flag = Flag_SUB;
    @(posedge CLK); #1;
    check("done_pulse_end", {30'b0, DONE, BUSY}, 32'h0);
    $display("op a=%08h b=%08h out=%08h flag=%0b lat=%0d busy=%0d", a, b, out, flag, lat, busy_cnt);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] out, output logic flag, output int lat, output int busy_cnt);
    A = a; B = b; EN = 1'b1; START = 1'b1;
    finish_op(a, b, out, flag, lat, busy_cnt);
  endtask

  vec_t        vecs [7];
  logic [31:0] out;
  logic        flag;
  int          lat, busy_cnt, dones, first_done;
  res_t        m;

  initial begin
    vecs[0] = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 3};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 3};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 3};
    vecs[3] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 3};
    vecs[4] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 3};
    vecs[5] = '{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 1'b0, 26};
    vecs[6] = '{32'h00800001, 32'h00800000, 32'h00000000, 1'b1, 4};

    RST = 1'b0; EN = 1'b0; START = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_out", OUT_SUB, 32'h0);
    check("reset_flags", {29'b0, Flag_SUB, BUSY, DONE}, 32'h0);
    RST = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, out, flag, lat, busy_cnt);
      check($sformatf("vec%0d_out", i), out, vecs[i].out);
      check($sformatf("vec%0d_flag", i), {31'b0, flag}, {31'b0, vecs[i].flag});
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].lat);
    end

    // START while busy and EN dropped mid-operation: the 23-shift op must finish untouched.
    A = 32'h3F800000; B = 32'h3F7FFFFF; EN = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    dones = 0; first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      if (DONE === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      if (c == 3) begin START = 1'b1; A = 32'h40400000; B = 32'h3F800000; end
      if (c == 4) begin START = 1'b0; EN = 1'b0; end
      @(posedge CLK); #1;
    end
    $display("busy_start dones=%0d first=%0d out=%08h", dones, first_done, OUT_SUB);
    check("busy_start_dones", dones, 1);
    check("busy_start_lat", first_done, 26);
    check("busy_start_out", OUT_SUB, 32'h34000000);

    // START with EN low is ignored.
    START = 1'b1; A = 32'h40400000; B = 32'h3F800000;
    busy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (BUSY !== 1'b0 || DONE !== 1'b0) busy_cnt++;
    end
    START = 1'b0; EN = 1'b1;
    $display("en_low busy_cycles=%0d out=%08h", busy_cnt, OUT_SUB);
    check("en_low_busy", busy_cnt, 0);
    check("en_low_out", OUT_SUB, 32'h34000000);

    // Back-to-back: START held in the DONE cycle is taken on the following IDLE edge.
    A = 32'h40400000; B = 32'h3F800000; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(lat, busy_cnt);
    A = 32'h3F800000; B = 32'h40400000; START = 1'b1;
    @(posedge CLK); #1;
    check("b2b_idle", {31'b0, BUSY}, 32'h0);
    finish_op(32'h3F800000, 32'h40400000, out, flag, lat, busy_cnt);
    check("b2b_out", out, 32'hC0000000);
    check("b2b_lat", lat, 3);

    // Asynchronous reset during NORM of the 23-shift case.
    A = 32'h3F800000; B = 32'h3F7FFFFF; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    check("pre_reset_busy", {31'b0, BUSY}, 32'h1);
    #2 RST = 1'b0;
    #1;
    $display("mid_reset out=%08h flag=%0b busy=%0b done=%0b", OUT_SUB, Flag_SUB, BUSY, DONE);
    check("mid_reset_out", OUT_SUB, 32'h0);
    check("mid_reset_flags", {29'b0, Flag_SUB, BUSY, DONE}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    run_op(32'h40400000, 32'h3F800000, out, flag, lat, busy_cnt);
    check("post_reset_out", out, 32'h40000000);
    check("post_reset_lat", lat, 3);

    // Random operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      int ea, eb, mode;
      logic [31:0] a, b;
      logic [22:0] fa, fb;
      mode = $urandom_range(0, 3);
      ea = (mode == 3) ? $urandom_range(1, 24) : $urandom_range(1, 254);
      fa = 23'($urandom);
      fb = 23'($urandom);
      case (mode)
        0: eb = $urandom_range(0, 254);
        1: begin
          eb = ea + $urandom_range(0, 2) - 1;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
        end
        2: eb = (i % 2 == 0) ? 0 : ea;
        default: begin eb = ea; fb = fa ^ 23'($urandom_range(0, 255)); end
      endcase
      a = {1'($urandom), 8'(ea), fa};
      b = {(mode == 3) ? a[31] : 1'($urandom), 8'(eb), fb};
      m = model(a, b);
      run_op(a, b, out, flag, lat, busy_cnt);
      check($sformatf("rnd%0d_out", i), out, m.out);
      check($sformatf("rnd%0d_flag", i), {31'b0, flag}, {31'b0, m.flag});
      check($sformatf("rnd%0d_lat", i), lat, m.lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
